// File: rtl/wb_dsp_pkg.sv
// Shared definitions for the DSP-side Wishbone SRAM slave and its burst
// address helper. Holds the Wishbone B3 cycle-type / burst-type encodings,
// the slave FSM state encoding and a constant-evaluable clog2.
package wb_dsp_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } wb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_dsp_burst_addr.sv
// Next-word pointer for Wishbone incrementing bursts. Shared with the DSP
// master's address generator. Only built when WB_DSP_SRAM_BURST_EN is defined.
//   ptr_i  : current word pointer (log2(depth) bits)
//   bte_i  : burst type (linear, wrap4, wrap8, wrap16)
//   next_o : pointer of the following beat
// Linear increments modulo depth; wrap-N increments only the low log2(N) bits.
`ifdef WB_DSP_SRAM_BURST_EN
module wb_dsp_burst_addr
  import wb_dsp_pkg::*;
#(
  parameter int depth = 1024
) (
  input  logic [clog2(depth)-1:0] ptr_i,
  input  logic [1:0]              bte_i,
  output logic [clog2(depth)-1:0] next_o
);

  localparam int PW = clog2(depth);

  logic [PW-1:0] wrap_mask;
  logic [PW-1:0] ptr_inc;

  assign ptr_inc = ptr_i + 1'b1;

  always_comb begin
    wrap_mask = '1;
    case (bte_i)
      BTE_LINEAR: wrap_mask = '1;
      BTE_WRAP4:  wrap_mask = PW'(5'd3);
      BTE_WRAP8:  wrap_mask = PW'(5'd7);
      BTE_WRAP16: wrap_mask = PW'(5'd15);
      default:    wrap_mask = '1;
    endcase
  end

  assign next_o = (ptr_i & ~wrap_mask) | (ptr_inc & wrap_mask);

endmodule
`endif

// File: rtl/wb_dsp_sram_slave.sv
// Wishbone B3 slave SRAM on the far end of the DSP master port. Holds
// equation descriptors, operands and results in a word-addressed array.
//
// Ports:
//   wb_clk, wb_rst            clock, asynchronous active-high reset
//   wb_adr_i                  byte address; word = adr[2 +: log2(depth)]
//   wb_dat_i / wb_dat_o       write / read data (dat_o holds when no ack)
//   wb_sel_i                  byte lane enables for writes
//   wb_we_i, wb_cyc_i, wb_stb_i
//   wb_cti_i, wb_bte_i        cycle type / burst type
//   wb_ack_o, wb_err_o        normal / error termination (never together)
//   wb_rty_o                  always 0
//
// Build option: WB_DSP_SRAM_BURST_EN adds registered incrementing bursts
// (BURST state, read prefetch, bte wrap). Without it cti/bte are ignored
// and every beat is a classic cycle.
//
// state | meaning
// IDLE  | no transfer in flight; ack/err low; samples cyc&stb and range
// WAIT  | counting down wait states before the first ack
// ACK   | single-cycle ack (or err); write commits here
// BURST | one ack per cycle while cyc&stb; pointer advances per beat
module wb_dsp_sram_slave
  import wb_dsp_pkg::*;
#(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int depth       = 1024,
  parameter int wait_states = 0
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int PW = clog2(depth);
  localparam int SW = dw / 8;

  wb_state_e     state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [dw-1:0] dat_q, dat_d;

  logic [dw-1:0] mem [depth];

  logic          req;
  logic          bad_adr;
  logic [PW-1:0] adr_idx;
  logic [PW-1:0] rd_idx;
  logic          rd_en;
  logic          mem_we;
  logic          ack;
  logic          err;

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_idx = wb_adr_i[2 +: PW];
  assign bad_adr = (wb_adr_i >> (2 + PW)) != '0;

`ifdef WB_DSP_SRAM_BURST_EN
  logic [PW-1:0] ptr_next;

  wb_dsp_burst_addr #(.depth(depth)) u_burst_addr (
    .ptr_i  (ptr_q),
    .bte_i  (wb_bte_i),
    .next_o (ptr_next)
  );
`else
  logic unused_burst_ctl;
  assign unused_burst_ctl = ^{wb_cti_i, wb_bte_i};
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    dat_d      = dat_q;
    rd_en      = 1'b0;
    rd_idx     = ptr_q;
    mem_we     = 1'b0;
    ack        = 1'b0;
    err        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Track the bus address so WAIT/ACK address the word sampled here.
        ptr_d = adr_idx;
        if (req) begin
          if (bad_adr) begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            err_d = 1'b0;
            if (wait_states > 0) begin
              wait_cnt_d = 4'(wait_states - 1);
              state_d    = ST_WAIT;
            end else begin
              rd_en   = 1'b1;
              rd_idx  = adr_idx;
              state_d = ST_ACK;
            end
          end
        end
      end

      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          rd_en   = 1'b1;
          state_d = ST_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_ACK: begin
        ack     = ~err_q;
        err     = err_q;
        // Commits even if cyc drops in this very cycle: the beat was acked.
        mem_we  = wb_we_i & ~err_q;
        state_d = ST_IDLE;
`ifdef WB_DSP_SRAM_BURST_EN
        if (!err_q && req && wb_cti_i == CTI_INCR) begin
          ptr_d   = ptr_next;
          rd_en   = 1'b1;
          rd_idx  = ptr_next;
          state_d = ST_BURST;
        end
`endif
      end

`ifdef WB_DSP_SRAM_BURST_EN
      ST_BURST: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wb_stb_i) begin
          ack    = 1'b1;
          mem_we = wb_we_i;
          if (wb_cti_i == CTI_EOB) begin
            state_d = ST_IDLE;
          end else begin
            // Prefetch the next beat so its data is ready with its ack.
            ptr_d  = ptr_next;
            rd_en  = 1'b1;
            rd_idx = ptr_next;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (rd_en) dat_d = mem[rd_idx];
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      dat_q      <= dat_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge wb_clk) begin
    if (mem_we) begin
      for (int i = 0; i < SW; i++) begin
        if (wb_sel_i[i]) mem[ptr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack;
  assign wb_err_o = err;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_dsp_sram_slave.sv
module tb_wb_dsp_sram_slave;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        is_err;
    logic        is_read;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] adr   [2];
  logic [31:0] dat_w [2];
  logic [3:0]  sel   [2];
  logic        we    [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic [2:0]  cti   [2];
  logic [1:0]  bte   [2];
  logic [31:0] dat_r [2];
  logic        ack   [2];
  logic        err   [2];
  logic        rty   [2];

  int n_vec = 0;
  int n_err = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [31:0] mdl  [2][DEPTH];
  logic [31:0] mval [2][DEPTH];

  wb_dsp_sram_slave #(.dw(32), .aw(32), .depth(DEPTH), .wait_states(0)) u_dut_w0 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]),
    .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_cti_i(cti[0]), .wb_bte_i(bte[0]), .wb_dat_o(dat_r[0]), .wb_ack_o(ack[0]),
    .wb_err_o(err[0]), .wb_rty_o(rty[0])
  );

  wb_dsp_sram_slave #(.dw(32), .aw(32), .depth(DEPTH), .wait_states(3)) u_dut_w3 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]),
    .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_cti_i(cti[1]), .wb_bte_i(bte[1]), .wb_dat_o(dat_r[1]), .wb_ack_o(ack[1]),
    .wb_err_o(err[1]), .wb_rty_o(rty[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Word touched by beat i of a burst starting at word w0.
  function automatic int beat_word(input int w0, input logic [1:0] b, input int i);
    int n;
    case (b)
      2'b01:   n = 4;
      2'b10:   n = 8;
      2'b11:   n = 16;
      default: n = 0;
    endcase
    if (n == 0) return (w0 + i) % DEPTH;
    return (w0 / n) * n + ((w0 % n) + i) % n;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, req);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic model_write(input int d, input int w, input logic [31:0] v, input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        mdl[d][w][8*i +: 8]  = v[8*i +: 8];
        mval[d][w][8*i +: 8] = 8'hFF;
      end
    end
  endtask

  function automatic exp_t read_exp(input int d, input int w);
    exp_t e;
    e.is_err  = 1'b0;
    e.is_read = 1'b1;
    e.data    = mdl[d][w];
    e.mask    = mval[d][w];
    return e;
  endfunction

  task automatic check_resp(input int d);
    exp_t e;
    chk("ack_err_excl", d, 32'(ack[d] & err[d]), 32'd0);
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_resp dut%0d: got ack=%0b err=%0b, expected no response", d, ack[d], err[d]);
      return;
    end
    if (d == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    chk("resp_err", d, 32'(err[d]), 32'(e.is_err));
    if (e.is_read) chk("read_data", d, dat_r[d] & e.mask, e.data & e.mask);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ack[d] || err[d]) check_resp(d);
      end
    end
  end

  task automatic wait_ack(input int d, output int lat);
    lat = 0;
    while (!(ack[d] || err[d])) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat > 64) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_timeout dut%0d: got no ack in %0d cycles, expected ack", d, lat);
        break;
      end
    end
  endtask

  task automatic bus_idle(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    cti[d] = 3'b000; bte[d] = 2'b00;
  endtask

  task automatic classic(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] v, input logic [3:0] s, output logic [31:0] rd);
    exp_t e;
    int   lat;
    int   wd;
    bit   bad;
    bad = (a >= 32'(DEPTH * 4));
    wd  = int'((a >> 2) % DEPTH);
    e   = '0;
    if (bad) e.is_err = 1'b1;
    else if (w) model_write(d, wd, v, s);
    else e = read_exp(d, wd);
    push(d, e);
    adr[d] = a; dat_w[d] = v; sel[d] = s; we[d] = w;
`ifdef WB_DSP_SRAM_BURST_EN
    cti[d] = 3'b000; bte[d] = 2'b00;
`else
    cti[d] = 3'($urandom); bte[d] = 2'($urandom);
`endif
    cyc[d] = 1'b1; stb[d] = 1'b1;
    wait_ack(d, lat);
    rd = dat_r[d];
    chk("classic_lat", d, 32'(lat), bad ? 32'd1 : 32'(ws(d) + 1));
    @(posedge clk);
    #1;
    chk("ack_pulse", d, {30'd0, ack[d], err[d]}, 32'd0);
    bus_idle(d);
  endtask

`ifdef WB_DSP_SRAM_BURST_EN
  task automatic burst(input int d, input bit w, input int w0, input logic [1:0] b,
                       input int nb, input bit stall_en);
    exp_t        e;
    int          lat;
    int          wd;
    logic [31:0] v;
    logic [3:0]  s;
    for (int i = 0; i < nb; i++) begin
      wd = beat_word(w0, b, i);
      v  = $urandom;
      s  = w ? 4'($urandom_range(1, 15)) : 4'hF;
      e  = '0;
      if (w) model_write(d, wd, v, s);
      else   e = read_exp(d, wd);
      push(d, e);
      adr[d]   = (i == 0) ? 32'(w0 * 4) : $urandom;
      dat_w[d] = v; sel[d] = s; we[d] = w; bte[d] = b;
      cti[d]   = (i == nb - 1) ? 3'b111 : 3'b010;
      cyc[d]   = 1'b1; stb[d] = 1'b1;
      wait_ack(d, lat);
      chk("burst_lat", d, 32'(lat), (i == 0) ? 32'(ws(d) + 1) : 32'd0);
      @(posedge clk);
      #1;
      if (stall_en && i < nb - 1 && $urandom_range(0, 2) == 0) begin
        stb[d] = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus_idle(d);
    chk("burst_end_ack", d, 32'(ack[d]), 32'd0);
  endtask
`endif

  logic [31:0] rd;
  int          lat;
  int          r;
  logic [31:0] a;

  initial begin
    for (int d = 0; d < 2; d++) begin
      bus_idle(d);
      adr[d] = '0; dat_w[d] = '0; sel[d] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mdl[d][i]  = '0;
        mval[d][i] = '0;
      end
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", d, 32'(ack[d]), 32'd0);
      chk("rst_err", d, 32'(err[d]), 32'd0);
      chk("rst_dat", d, dat_r[d], 32'd0);
      chk("rst_rty", d, 32'(rty[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Byte lanes on the zero-wait slave.
    classic(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    classic(0, 1, 32'h10, 32'h000000AA, 4'h1, rd);
    classic(0, 0, 32'h10, 32'h0, 4'hF, rd);
    chk("byte_lane", 0, rd, 32'hDEADBEAA);

    // Three wait states.
    classic(1, 1, 32'h0, 32'h12345678, 4'hF, rd);
    classic(1, 0, 32'h0, 32'h0, 4'hF, rd);
    chk("wait_read", 1, rd, 32'h12345678);

    // Out of range leaves the array alone.
    classic(0, 1, 32'h0, 32'h0BADF00D, 4'hF, rd);
    classic(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd);
    classic(0, 0, 32'h0, 32'h0, 4'hF, rd);
    chk("oor_keep", 0, rd, 32'h0BADF00D);
    classic(1, 1, 32'h8000_0004, 32'hFFFFFFFF, 4'hF, rd);

`ifdef WB_DSP_SRAM_BURST_EN
    // Wrap-4 read from word 6: 6,7,4,5.
    for (int i = 4; i < 8; i++) classic(0, 1, 32'(i * 4), 32'h4444_0000 + 32'(i), 4'hF, rd);
    burst(0, 0, 6, 2'b01, 4, 1'b0);

    // Linear write burst aborted after two beats.
    for (int i = 16; i < 19; i++) classic(0, 1, 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, rd);
    model_write(0, 16, 32'hA0A0_0010, 4'hF);
    model_write(0, 17, 32'hA0A0_0011, 4'hF);
    push(0, exp_t'(0));
    push(0, exp_t'(0));
    adr[0] = 32'h40; dat_w[0] = 32'hA0A0_0010; sel[0] = 4'hF; we[0] = 1'b1;
    cti[0] = 3'b010; bte[0] = 2'b00; cyc[0] = 1'b1; stb[0] = 1'b1;
    wait_ack(0, lat);
    @(posedge clk);
    #1;
    dat_w[0] = 32'hA0A0_0011;
    wait_ack(0, lat);
    chk("abort_beat2_lat", 0, 32'(lat), 32'd0);
    @(posedge clk);
    #1;
    dat_w[0] = 32'hA0A0_0012;
    bus_idle(0);
    @(posedge clk);
    #1;
    chk("abort_ack", 0, 32'(ack[0]), 32'd0);
    classic(0, 0, 32'h40, 32'h0, 4'hF, rd);
    chk("abort_w16", 0, rd, 32'hA0A0_0010);
    classic(0, 0, 32'h44, 32'h0, 4'hF, rd);
    chk("abort_w17", 0, rd, 32'hA0A0_0011);
    classic(0, 0, 32'h48, 32'h0, 4'hF, rd);
    chk("abort_w18", 0, rd, 32'h1111_0012);

    // Linear burst across the top of the array.
    burst(0, 1, DEPTH - 2, 2'b00, 4, 1'b1);
    burst(1, 1, DEPTH - 1, 2'b00, 3, 1'b0);
    for (int i = 0; i < 4; i++) classic(0, 0, 32'(beat_word(DEPTH - 2, 2'b00, i) * 4), 32'h0, 4'hF, rd);
    burst(1, 0, DEPTH - 1, 2'b00, 3, 1'b1);
`endif

    // Reset while a transfer is acking on the zero-wait slave.
    classic(0, 1, 32'h14, 32'h5555_0005, 4'hF, rd);
    adr[0] = 32'h14; we[0] = 1'b0; sel[0] = 4'hF;
`ifdef WB_DSP_SRAM_BURST_EN
    push(0, read_exp(0, 5));
    cti[0] = 3'b010; bte[0] = 2'b00; cyc[0] = 1'b1; stb[0] = 1'b1;
    wait_ack(0, lat);
    @(posedge clk);
    #1;
    chk("burst_live", 0, 32'(ack[0]), 32'd1);
`else
    cti[0] = 3'b000; cyc[0] = 1'b1; stb[0] = 1'b1;
    wait_ack(0, lat);
    chk("pre_rst_dat", 0, dat_r[0], 32'h5555_0005);
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 0, 32'(ack[0]), 32'd0);
    chk("mid_rst_err", 0, 32'(err[0]), 32'd0);
    chk("mid_rst_dat", 0, dat_r[0], 32'd0);
    chk("mid_rst_dat", 1, dat_r[1], 32'd0);
    bus_idle(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    classic(0, 0, 32'h14, 32'h0, 4'hF, rd);
    chk("rst_keep_w5", 0, rd, 32'h5555_0005);

    // Randomized traffic on both slaves.
    for (int k = 0; k < 70; k++) begin
      for (int d = 0; d < 2; d++) begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          classic(d, 1, 32'($urandom_range(0, 31) * 4), $urandom, 4'($urandom), rd);
        end else if (r == 8) begin
          a = (32'($urandom_range(1, 1048575)) << 12) | ($urandom & 32'hFFC);
          classic(d, $urandom_range(0, 1) == 1, a, $urandom, 4'hF, rd);
        end else if (r == 9) begin
`ifdef WB_DSP_SRAM_BURST_EN
          burst(d, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
                2'($urandom), $urandom_range(1, 9), 1'b1);
`else
          classic(d, 0, 32'($urandom_range(0, 31) * 4), 32'h0, 4'hF, rd);
`endif
        end else begin
          classic(d, 0, 32'($urandom_range(0, 31) * 4), 32'h0, 4'hF, rd);
        end
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("sb0_drained", 0, 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 1, 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
